// File: rtl/riscv_ifetch_pkg.sv
// Shared fetch-unit defaults: widths, reset pc,
// alignment mask and fetch FSM encodings.
package riscv_ifetch_pkg;

  localparam int PC_W_DEF   = 15;
  localparam int INST_W_DEF = 32;
  localparam int RESET_PC_DEF = 0;

  localparam logic [1:0] ALIGN_MASK = 2'b00;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  function automatic logic misaligned(
    input logic [1:0] lsb
  );
    return lsb != ALIGN_MASK;
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Prefetch buffer: small synchronous FIFO with flush.
// Head entry is presented combinationally on o_dout.
module riscv_fetch_fifo #(
  parameter int W     = 47,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [W-1:0]               i_din,
  output logic [W-1:0]               o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CNT_FULL);
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rd];

  // Push into a full buffer is legal only alongside a pop.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_din;
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      if (w_push & ~w_pop)
        r_cnt <= r_cnt + (AW+1)'(1);
      else if (w_pop & ~w_push)
        r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction fetch: pc register, run/fault FSM,
// redirect handling and prefetch buffer to decode.
module riscv_ifetch
  import riscv_ifetch_pkg::*;
#(
  parameter int PC_WIDTH   = PC_W_DEF,
  parameter int INST_WIDTH = INST_W_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC =
    PC_WIDTH'(RESET_PC_DEF),
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  output logic [PC_WIDTH-1:0]   imem_pc,
  input  logic [INST_WIDTH-1:0] imem_inst,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [INST_WIDTH-1:0] id_inst,
  output logic [PC_WIDTH-1:0]   id_pc,
  output logic                  fetch_fault
);

  localparam int EW = PC_WIDTH + INST_WIDTH;
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(BUF_DEPTH);

  logic [1:0]          r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_fault;
  logic                w_pop;
  logic                w_push;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  logic [EW-1:0]       w_head;

  assign imem_pc     = r_pc;
  assign fetch_fault = r_fault;
  assign id_valid    = ~w_empty;
  assign id_pc       = w_head[EW-1:INST_WIDTH];
  assign id_inst     = w_head[INST_WIDTH-1:0];

  assign w_pop  = id_valid & id_ready;
  assign w_push = (r_state == S_RUN) & fetch_en &
                  ~redirect_valid & (~w_full | w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= RESET_PC;
      r_state <= S_IDLE;
      r_fault <= 1'b0;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
      if (misaligned(redirect_pc[1:0])) begin
        r_state <= S_FAULT;
        r_fault <= 1'b1;
      end else begin
        r_state <= fetch_en ? S_RUN : S_IDLE;
        r_fault <= 1'b0;
      end
    end else begin
      if (w_push)
        r_pc <= r_pc + PC_WIDTH'(4);
      unique case (r_state)
        S_IDLE:  if (fetch_en) r_state <= S_RUN;
        S_RUN:   if (!fetch_en) r_state <= S_IDLE;
        default: r_state <= r_state;
      endcase
    end
  end

  riscv_fetch_fifo #(
    .W     (EW),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop & ~redirect_valid),
    .i_flush (redirect_valid),
    .i_din   ({r_pc, imem_inst}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  a_count_bound: assert property (
    @(posedge clk) disable iff (!reset)
    w_count <= CNT_FULL
  );

endmodule

// File: tb/tb_riscv_ifetch.sv
// Directed bench for riscv_ifetch with a
// combinational imem model.
module tb_riscv_ifetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [14:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [14:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [14:0] id_pc;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_ifetch dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .fetch_fault    (fetch_fault)
  );

  // addi x(pc[6:2]), x0, pc[13:2]
  function automatic logic [31:0] exp_inst(
    input logic [14:0] pc
  );
    logic [31:0] r;
    r = 32'h0000_0013;
    r[31:20] = pc[13:2];
    r[11:7]  = pc[6:2];
    return r;
  endfunction

  always_comb begin
    imem_inst = 32'hDEAD_BEEF;
    if (imem_pc[1:0] == 2'b00)
      imem_inst = exp_inst(imem_pc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(
    input string       nm,
    input logic [14:0] pc
  );
    checks++;
    if (id_valid !== 1'b1 || id_pc !== pc ||
        id_inst !== exp_inst(pc)) begin
      errors++;
      $display("FAIL %s: valid=%b pc=%h inst=%h want pc=%h inst=%h",
               nm, id_valid, id_pc, id_inst, pc, exp_inst(pc));
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    fetch_en = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (id_valid !== 1'b0 || id_pc !== 15'h0 ||
        id_inst !== 32'h0 || fetch_fault !== 1'b0 ||
        imem_pc !== 15'h0) begin
      errors++;
      $display("FAIL reset: v=%b pc=%h inst=%h f=%b ipc=%h want zeros",
               id_valid, id_pc, id_inst, fetch_fault, imem_pc);
    end
    reset = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    reset = 1'b1;
    fetch_en = 1'b1;
    id_ready = 1'b1;
    step();
    checks++;
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_lat: id_valid=%b want 0", id_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk_head("stream", 15'(i * 4));
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    reset = 1'b1;
    fetch_en = 1'b1;
    id_ready = 1'b0;
    repeat (5) step();
    chk_head("bp_hold", 15'h0);
    checks++;
    if (imem_pc !== 15'h8) begin
      errors++;
      $display("FAIL bp_imem_pc: got %h want 0008", imem_pc);
    end
    id_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_head("bp_resume", 15'(i * 4));
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc = 15'h100;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || imem_pc !== 15'h100) begin
      errors++;
      $display("FAIL redir_flush: v=%b ipc=%h want 0 0100",
               id_valid, imem_pc);
    end
    step();
    chk_head("redir_first", 15'h100);
    step();
    chk_head("redir_next", 15'h104);
  endtask

  task automatic test_fault();
    redirect_valid = 1'b1;
    redirect_pc = 15'h102;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (fetch_fault !== 1'b1 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_set: f=%b v=%b want 1 0",
               fetch_fault, id_valid);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (id_valid !== 1'b0 || imem_pc !== 15'h102 ||
          fetch_fault !== 1'b1) begin
        errors++;
        $display("FAIL fault_hold: v=%b ipc=%h f=%b want 0 0102 1",
                 id_valid, imem_pc, fetch_fault);
      end
    end
    redirect_valid = 1'b1;
    redirect_pc = 15'h200;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_clr: f=%b want 0", fetch_fault);
    end
    step();
    chk_head("fault_recover", 15'h200);
  endtask

  task automatic test_wrap();
    logic [14:0] exp_pc [3];
    exp_pc[0] = 15'h7FF8;
    exp_pc[1] = 15'h7FFC;
    exp_pc[2] = 15'h0000;
    redirect_valid = 1'b1;
    redirect_pc = 15'h7FF8;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_head("wrap", exp_pc[i]);
    end
  endtask

  task automatic test_async_reset();
    step();
    chk_head("pre_reset", 15'h4);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || id_pc !== 15'h0 ||
        id_inst !== 32'h0 || imem_pc !== 15'h0 ||
        fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: v=%b pc=%h inst=%h ipc=%h f=%b",
               id_valid, id_pc, id_inst, imem_pc, fetch_fault);
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_lat: id_valid=%b want 0", id_valid);
    end
    step();
    chk_head("restart", 15'h0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
